// File: rtl/rs_gf8_pkg.sv
// Shared GF(2^3) definitions for the RS(7,3) encoder/decoder pair:
// field constants, generator coefficients, FSM states and a generic multiplier.
package rs_gf8_pkg;

    localparam int SYM_W = 3;
    localparam int N     = 7;
    localparam int K     = 3;

    localparam logic [3:0] PRIM_POLY = 4'b1011;

    // g(x) = x^4 + g3*x^3 + g2*x^2 + g1*x + g0, indexed g0..g3
    localparam logic [2:0] G_COEF [0:3] = '{3'd3, 3'd2, 3'd1, 3'd3};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rs_state_e;

    function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] w_acc;
        logic [2:0] w_a;
        w_acc = '0;
        w_a   = a;
        for (int i = 0; i < 3; i++) begin
            if (b[i]) begin
                w_acc = w_acc ^ w_a;
            end
            // multiply by alpha, folding x^3 back as x+1
            w_a = w_a[2] ? ({w_a[1:0], 1'b0} ^ PRIM_POLY[2:0]) : {w_a[1:0], 1'b0};
        end
        return w_acc;
    endfunction

endpackage

// File: rtl/rs_gf8_cmul.sv
// Constant-coefficient GF(2^3) multiplier: o_y = i_a * COEF.
module rs_gf8_cmul
    import rs_gf8_pkg::*;
#(
    parameter logic [2:0] COEF = 3'd1
) (
    input  logic [2:0] i_a,
    output logic [2:0] o_y
);

    assign o_y = gf8_mul(i_a, COEF);

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(7,3) encoder over GF(2^3) using a serial 4-stage LFSR.
// Optional macro RS_ERR_INJECT_EN adds err_mask[20:0], XORed into the codeword load.
module rs_encoder #(
    parameter int SYM_W = 3,
    parameter int N     = 7,
    parameter int K     = 3
) (
`ifdef RS_ERR_INJECT_EN
    input  logic [N*SYM_W-1:0] err_mask,
`endif
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [K*SYM_W-1:0] msg,
    input  logic               msg_valid,
    output logic               msg_ready,
    output logic [N*SYM_W-1:0] codeword,
    output logic               cw_valid,
    input  logic               cw_ready
);

    import rs_gf8_pkg::*;

    if (SYM_W != rs_gf8_pkg::SYM_W || N != rs_gf8_pkg::N || K != rs_gf8_pkg::K) begin : g_param_check
        $error("rs_encoder supports only SYM_W=3, N=7, K=3");
    end

    rs_state_e          r_state;
    rs_state_e          w_state_nxt;
    logic [1:0]         r_cnt;
    logic [1:0]         w_cnt_nxt;
    logic               w_accept;
    logic               w_shift;
    logic               w_load;

    logic [K*SYM_W-1:0] r_msg;
    logic [2:0]         r_lfsr [0:3];
    logic [N*SYM_W-1:0] r_codeword;

    logic [2:0]         w_sym;
    logic [2:0]         w_fb;
    logic [2:0]         w_gfb  [0:3];
    logic [2:0]         w_lfsr_nxt [0:3];
    logic [N*SYM_W-1:0] w_cw_load;
    logic [N*SYM_W-1:0] w_mask;

`ifdef RS_ERR_INJECT_EN
    assign w_mask = err_mask;
`else
    assign w_mask = '0;
`endif

    // ---- control FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else if (enable) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (msg_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == 2'd2) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = 2'd0;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 2'd1;
                end
            end
            DONE: begin
                if (cw_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    // ---- LFSR datapath: highest-degree message symbol first
    always_comb begin
        case (r_cnt)
            2'd0:    w_sym = r_msg[2:0];
            2'd1:    w_sym = r_msg[5:3];
            default: w_sym = r_msg[8:6];
        endcase
    end

    assign w_fb = w_sym ^ r_lfsr[3];

    rs_gf8_cmul #(.COEF(G_COEF[0])) u_cmul0 (.i_a(w_fb), .o_y(w_gfb[0]));
    rs_gf8_cmul #(.COEF(G_COEF[1])) u_cmul1 (.i_a(w_fb), .o_y(w_gfb[1]));
    rs_gf8_cmul #(.COEF(G_COEF[2])) u_cmul2 (.i_a(w_fb), .o_y(w_gfb[2]));
    rs_gf8_cmul #(.COEF(G_COEF[3])) u_cmul3 (.i_a(w_fb), .o_y(w_gfb[3]));

    assign w_lfsr_nxt[0] = w_gfb[0];
    assign w_lfsr_nxt[1] = r_lfsr[0] ^ w_gfb[1];
    assign w_lfsr_nxt[2] = r_lfsr[1] ^ w_gfb[2];
    assign w_lfsr_nxt[3] = r_lfsr[2] ^ w_gfb[3];

    // Parity comes from the LFSR next-state so the codeword loads on the final shift edge
    assign w_cw_load = {w_lfsr_nxt[0], w_lfsr_nxt[1], w_lfsr_nxt[2], w_lfsr_nxt[3], r_msg} ^ w_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_msg      <= '0;
            r_lfsr[0]  <= '0;
            r_lfsr[1]  <= '0;
            r_lfsr[2]  <= '0;
            r_lfsr[3]  <= '0;
            r_codeword <= '0;
        end else if (enable) begin
            if (w_accept) begin
                r_msg     <= msg;
                r_lfsr[0] <= '0;
                r_lfsr[1] <= '0;
                r_lfsr[2] <= '0;
                r_lfsr[3] <= '0;
            end else if (w_shift) begin
                r_lfsr[0] <= w_lfsr_nxt[0];
                r_lfsr[1] <= w_lfsr_nxt[1];
                r_lfsr[2] <= w_lfsr_nxt[2];
                r_lfsr[3] <= w_lfsr_nxt[3];
            end
            if (w_load) begin
                r_codeword <= w_cw_load;
            end
        end
    end

    // ---- handshake outputs
    assign msg_ready = enable & ~reset & (r_state == IDLE);
    assign cw_valid  = enable & (r_state == DONE);
    assign codeword  = r_codeword;

endmodule

// File: tb/tb_rs_encoder.sv
// Bench for rs_encoder: known-answer table, random words vs a polynomial-division
// reference model with syndrome checks, and hand-written stall/enable/reset sequences.
module tb_rs_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [8:0]  msg;
    logic        msg_valid;
    logic        msg_ready;
    logic [20:0] codeword;
    logic        cw_valid;
    logic        cw_ready;
`ifdef RS_ERR_INJECT_EN
    logic [20:0] err_mask;
`endif

    int vectors     = 0;
    int miscompares = 0;

    int          exp_t [0:6];
    int          log_t [0:7];
    logic [2:0]  gp    [0:4];

    typedef struct packed {
        logic [8:0]  msg;
        logic [20:0] cw;
    } vec_t;

    vec_t tbl [5];

    rs_encoder dut (
`ifdef RS_ERR_INJECT_EN
        .err_mask  (err_mask),
`endif
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .msg       (msg),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .codeword  (codeword),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---- reference model: log/antilog field arithmetic and polynomial long division
    task automatic build_tables();
        int e;
        e = 1;
        for (int i = 0; i < 7; i++) begin
            exp_t[i] = e;
            log_t[e] = i;
            e = e << 1;
            if ((e & 8) != 0) e = e ^ 11;
        end
        log_t[0] = 0;
        gp[0] = 3'd1;
        for (int k = 1; k <= 4; k++) gp[k] = 3'd0;
        for (int r = 1; r <= 4; r++) begin
            for (int k = 4; k >= 1; k--) gp[k] = gp[k-1] ^ gmul(gp[k], 3'(exp_t[r]));
            gp[0] = gmul(gp[0], 3'(exp_t[r]));
        end
    endtask

    function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
        if (a == 3'd0 || b == 3'd0) return 3'd0;
        return 3'(exp_t[(log_t[a] + log_t[b]) % 7]);
    endfunction

    function automatic logic [20:0] model_cw(input logic [8:0] m);
        logic [2:0] rem [0:6];
        logic [2:0] c;
        for (int i = 0; i < 7; i++) rem[i] = 3'd0;
        rem[4] = m[8:6];
        rem[5] = m[5:3];
        rem[6] = m[2:0];
        for (int d = 6; d >= 4; d--) begin
            c = rem[d];
            for (int k = 0; k <= 4; k++) rem[d-4+k] = rem[d-4+k] ^ gmul(c, gp[k]);
        end
        return {rem[0], rem[1], rem[2], rem[3], m[8:6], m[5:3], m[2:0]};
    endfunction

    function automatic logic [2:0] peval(input logic [20:0] cw, input int j);
        logic [2:0] acc;
        logic [2:0] x;
        acc = 3'd0;
        x   = 3'(exp_t[j]);
        for (int i = 6; i >= 0; i--) acc = gmul(acc, x) ^ cw[20-3*i -: 3];
        return acc;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Offers m, waits (bounded) for the codeword; lat counts edges after acceptance.
    task automatic send(input logic [8:0] m, output logic [20:0] cw, output int lat);
        int n;
        msg       = m;
        msg_valid = 1'b1;
        n = 0;
        while (!msg_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("msg_ready_before_send", 64'(msg_ready), 64'd1);
        @(posedge clk); #1;
        msg_valid = 1'b0;
        lat = 0;
        while (!cw_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        cw = codeword;
    endtask

    initial begin
        logic [20:0] cw;
        logic [8:0]  m;
        logic [8:0]  m2;
        int          lat;

        build_tables();

        tbl[0] = '{msg: 9'b000_000_000, cw: 21'b000_000_000_000_000_000_000};
        tbl[1] = '{msg: 9'b001_000_000, cw: 21'b011_010_001_011_001_000_000};
        tbl[2] = '{msg: 9'b010_000_000, cw: 21'b110_100_010_110_010_000_000};
        tbl[3] = '{msg: 9'b000_001_000, cw: 21'b101_101_001_100_000_001_000};
        tbl[4] = '{msg: 9'b000_000_001, cw: 21'b111_110_001_110_000_000_001};

        reset     = 1'b1;
        enable    = 1'b1;
        msg       = 9'd0;
        msg_valid = 1'b0;
        cw_ready  = 1'b1;
`ifdef RS_ERR_INJECT_EN
        err_mask  = 21'd0;
`endif

        repeat (2) @(posedge clk);
        #1;
        check("reset_msg_ready", 64'(msg_ready), 64'd0);
        check("reset_cw_valid",  64'(cw_valid),  64'd0);
        check("reset_codeword",  64'(codeword),  64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_msg_ready", 64'(msg_ready), 64'd1);

        // ---- known-answer table
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].msg, cw, lat);
            check($sformatf("table%0d_codeword", i), 64'(cw), 64'(tbl[i].cw));
            check($sformatf("table%0d_latency", i), 64'(lat), 64'd3);
            @(posedge clk); #1;
            check($sformatf("table%0d_cw_valid_drop", i), 64'(cw_valid), 64'd0);
        end

        // ---- random words vs model, plus zero syndromes at alpha^1..alpha^4
        for (int i = 0; i < 40; i++) begin
            m = 9'($urandom);
            send(m, cw, lat);
            check($sformatf("rand%0d_codeword", i), 64'(cw), 64'(model_cw(m)));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd3);
            for (int j = 1; j <= 4; j++)
                check($sformatf("rand%0d_syndrome%0d", i, j), 64'(peval(cw, j)), 64'd0);
            @(posedge clk); #1;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // ---- downstream stall in DONE with msg_valid toggling
        m  = 9'b101_011_110;
        m2 = 9'b010_111_001;
        cw_ready = 1'b0;
        send(m, cw, lat);
        check("stall_codeword", 64'(cw), 64'(model_cw(m)));
        msg = m2;
        for (int i = 0; i < 10; i++) begin
            msg_valid = i[0];
            @(posedge clk); #1;
            check($sformatf("stall%0d_codeword", i),  64'(codeword),  64'(model_cw(m)));
            check($sformatf("stall%0d_msg_ready", i), 64'(msg_ready), 64'd0);
            check($sformatf("stall%0d_cw_valid", i),  64'(cw_valid),  64'd1);
        end
        msg_valid = 1'b0;
        cw_ready  = 1'b1;
        @(posedge clk); #1;
        check("stall_release_cw_valid",  64'(cw_valid),  64'd0);
        check("stall_release_hold",      64'(codeword),  64'(model_cw(m)));
        check("stall_release_msg_ready", 64'(msg_ready), 64'd1);
        send(m2, cw, lat);
        check("after_stall_codeword", 64'(cw), 64'(model_cw(m2)));
        @(posedge clk); #1;

        // ---- enable dropped for 4 cycles after the first shift
        m = 9'b110_001_101;
        msg = m;
        msg_valid = 1'b1;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        @(posedge clk); #1;
        enable = 1'b0;
        #1;
        check("enable_low_msg_ready", 64'(msg_ready), 64'd0);
        check("enable_low_cw_valid",  64'(cw_valid),  64'd0);
        repeat (4) @(posedge clk);
        #1;
        check("enable_low_hold_cw_valid", 64'(cw_valid), 64'd0);
        enable = 1'b1;
        lat = 5;
        while (!cw_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("enable_latency",  64'(lat),      64'd7);
        check("enable_codeword", 64'(codeword), 64'(model_cw(m)));
        enable = 1'b0;
        #1;
        check("enable_low_done_cw_valid", 64'(cw_valid), 64'd0);
        enable = 1'b1;
        #1;
        check("enable_restore_cw_valid", 64'(cw_valid), 64'd1);
        @(posedge clk); #1;
        check("enable_handoff_cw_valid", 64'(cw_valid), 64'd0);

        // ---- asynchronous reset between edges mid-shift
        m = 9'b011_100_111;
        msg = m;
        msg_valid = 1'b1;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_cw_valid",  64'(cw_valid),  64'd0);
        check("midreset_msg_ready", 64'(msg_ready), 64'd0);
        check("midreset_codeword",  64'(codeword),  64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("postreset_msg_ready", 64'(msg_ready), 64'd1);
        check("postreset_cw_valid",  64'(cw_valid),  64'd0);
        send(m, cw, lat);
        check("postreset_codeword", 64'(cw), 64'(model_cw(m)));
        check("postreset_latency",  64'(lat), 64'd3);
        @(posedge clk); #1;

`ifdef RS_ERR_INJECT_EN
        err_mask = 21'h000007;
        send(9'b001_000_000, cw, lat);
        check("errinj_codeword", 64'(cw), 64'(21'b011_010_001_011_001_000_111));
        @(posedge clk); #1;
        err_mask = 21'd0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
